// File: rtl/collision_checker.sv
// collision_checker
//   Decides whether a candidate tetromino placement collides with the playfield
//   walls/floor or with already-settled blocks. Four (y,x) cells are latched on
//   an accepted start, bounds-checked together in one cycle, then looked up one
//   at a time in the board occupancy memory (1-cycle read latency). The first
//   occupied cell ends the check early.
//
// Handshakes:
//   start/done : start is sampled only while idle (busy=0, done=0). The accepting
//                edge latches all eight coordinates and clears collision. done is
//                a single-cycle pulse; collision is valid from the done cycle until
//                the next accepted start. start seen while busy or during done is
//                dropped, never queued.
//   board read : board_rd_en is high for one cycle with the address on
//                board_rd_y/board_rd_x; board_rd_data is sampled in the following
//                cycle. Address lines are forced to 0 whenever board_rd_en is low.
//
// Debug: o_dbg_state exposes the FSM state register.
module collision_checker #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [4:0] y1,
  input  logic [3:0] x1,
  input  logic [4:0] y2,
  input  logic [3:0] x2,
  input  logic [4:0] y3,
  input  logic [3:0] x3,
  input  logic [4:0] y4,
  input  logic [3:0] x4,
  output logic       board_rd_en,
  output logic [4:0] board_rd_y,
  output logic [3:0] board_rd_x,
  input  logic       board_rd_data,
  output logic       busy,
  output logic       done,
  output logic       collision,
  output logic [2:0] o_dbg_state
);

  // FSM encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BOUND = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Bounds held one bit wider than the coordinates so a board of the full
  // 16/32 extent still compares correctly (every coordinate is then legal).
  localparam logic [4:0] LP_W = 5'(BOARD_W);
  localparam logic [5:0] LP_H = 6'(BOARD_H);

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [4:0] r_cell_y [4];
  logic [3:0] r_cell_x [4];
  logic [1:0] r_idx;
  logic       r_collision;

  logic [4:0] w_in_y [4];
  logic [3:0] w_in_x [4];
  logic [3:0] w_oob;
  logic       w_any_oob;
  logic       w_start_accept;
  logic       w_last_cell;
  logic [4:0] w_sel_y;
  logic [3:0] w_sel_x;

  // Gather the flat coordinate ports into indexable arrays
  assign w_in_y[0] = y1;
  assign w_in_x[0] = x1;
  assign w_in_y[1] = y2;
  assign w_in_x[1] = x2;
  assign w_in_y[2] = y3;
  assign w_in_x[2] = x3;
  assign w_in_y[3] = y4;
  assign w_in_x[3] = x4;

  assign w_start_accept = (r_state == S_IDLE) && start;
  assign w_last_cell    = (r_idx == 2'd3);
  assign w_sel_y        = r_cell_y[r_idx];
  assign w_sel_x        = r_cell_x[r_idx];

  // Per-cell bounds test on the latched coordinates; a wrapped x (e.g. 0-1=15)
  // simply lands outside the board and needs no special handling.
  always_comb begin
    w_oob = '0;
    for (int i = 0; i < 4; i++) begin
      w_oob[i] = ({1'b0, r_cell_x[i]} >= LP_W) || ({1'b0, r_cell_y[i]} >= LP_H);
    end
  end

  assign w_any_oob = |w_oob;

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_BOUND;
        end
      end
      S_BOUND: begin
        if (w_any_oob) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (board_rd_data || w_last_cell) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; reset aborts any check without a done pulse
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Coordinate latch, loaded only on the accepting edge
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) begin
        r_cell_y[i] <= '0;
        r_cell_x[i] <= '0;
      end
    end else if (w_start_accept) begin
      for (int i = 0; i < 4; i++) begin
        r_cell_y[i] <= w_in_y[i];
        r_cell_x[i] <= w_in_x[i];
      end
    end
  end

  // Cell index: restarts at 0 per check, advances after each free cell
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_idx <= '0;
    end else if (w_start_accept) begin
      r_idx <= '0;
    end else if ((r_state == S_WAIT) && !board_rd_data && !w_last_cell) begin
      r_idx <= r_idx + 2'd1;
    end
  end

  // Result flag: cleared on accept, set by a bounds hit or an occupied cell
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_collision <= 1'b0;
    end else if (w_start_accept) begin
      r_collision <= 1'b0;
    end else if ((r_state == S_BOUND) && w_any_oob) begin
      r_collision <= 1'b1;
    end else if ((r_state == S_WAIT) && board_rd_data) begin
      r_collision <= 1'b1;
    end
  end

  // Outputs decoded from state so reset clears them immediately
  always_comb begin
    busy        = (r_state == S_BOUND) || (r_state == S_REQ) || (r_state == S_WAIT);
    done        = (r_state == S_DONE);
    board_rd_en = (r_state == S_REQ);
    board_rd_y  = '0;
    board_rd_x  = '0;
    if (r_state == S_REQ) begin
      board_rd_y = w_sel_y;
      board_rd_x = w_sel_x;
    end
    collision   = r_collision;
    o_dbg_state = r_state;
  end

endmodule
